spike_rate_decoder: RTL and testbench

Downstream consumer of the SNN core's two output spikes. Counts spikes per output neuron over a programmable window of delay-clock time steps, then presents a rate-decoded winner and both counts with a valid/ack handshake. Sits beside the debug path, fed by the core's output_spikes and the clock divider's delay_clk. delay_clk is generated in the system_clock domain, so no CDC is needed.

---
 rtl/snn_pkg.sv | 9 +
 rtl/sat_counter.sv | 16 +
 rtl/spike_rate_decoder.sv | 90 +++++++++
 tb/tb_spike_rate_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding, winner codes and counter width for the SNN output path
package snn_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COUNT = 2'd1, ST_REPORT = 2'd2} state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_N0   = 2'b01;
  localparam logic [1:0] WIN_N1   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clear/increment counter saturating at all-ones; o_next is the value it takes at the next edge
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_next
);
  logic [W-1:0] r_q;
  assign o_next = (i_inc && r_q != '1) ? r_q + W'(1) : r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_q <= '0;
    else r_q <= i_clr ? '0 : o_next;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts output spikes over a window of time steps and reports a rate-decoded winner
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int N_OUT = 2,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             time_step,
  input  logic [N_OUT-1:0] output_spikes,
  input  logic [CNT_W-1:0] window_len,
  input  logic             result_ack,
  output logic [CNT_W-1:0] spike_count0,
  output logic [CNT_W-1:0] spike_count1,
  output logic [1:0]       winner,
  output logic             result_valid,
  output logic             busy
);
  state_t           r_state;
  logic             r_step_prev;
  logic [CNT_W:0]   r_steps;
  logic [CNT_W:0]   r_win;
  logic             w_step_edge;
  logic             w_inc_en;
  logic             w_start;
  logic             w_final;
  logic [CNT_W:0]   w_win_len;
  logic [CNT_W:0]   w_steps_inc;
  logic [CNT_W-1:0] w_n0;
  logic [CNT_W-1:0] w_n1;
  logic [1:0]       w_win_code;
  assign w_step_edge = time_step & ~r_step_prev;
  assign w_inc_en    = (r_state == ST_COUNT) && enable && w_step_edge;
  assign w_start     = enable && (r_state == ST_IDLE || (r_state == ST_REPORT && result_ack));
  assign w_win_len   = (window_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, window_len};
  assign w_steps_inc = r_steps + (CNT_W + 1)'(1);
  assign w_final     = w_inc_en && (w_steps_inc == r_win);
  assign w_win_code  = (w_n0 > w_n1) ? WIN_N0 : (w_n1 > w_n0) ? WIN_N1 : (w_n0 != '0) ? WIN_TIE : WIN_NONE;
  assign busy        = (r_state == ST_COUNT);
  // next-values include the final step's sample, so the copy below needs no extra cycle
  sat_counter #(.W(CNT_W)) u_cnt0 (
    .i_clk(system_clock), .i_rst_n(reset), .i_clr(w_start), .i_inc(w_inc_en & output_spikes[0]), .o_next(w_n0)
  );
  sat_counter #(.W(CNT_W)) u_cnt1 (
    .i_clk(system_clock), .i_rst_n(reset), .i_clr(w_start), .i_inc(w_inc_en & output_spikes[1]), .o_next(w_n1)
  );
  always_ff @(posedge system_clock or negedge reset)
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_step_prev  <= 1'b0;
      r_steps      <= '0;
      r_win        <= '0;
      spike_count0 <= '0;
      spike_count1 <= '0;
      winner       <= WIN_NONE;
      result_valid <= 1'b0;
    end else begin
      r_step_prev <= time_step;
      case (r_state)
        ST_IDLE:
          if (enable) begin
            r_win   <= w_win_len;
            r_steps <= '0;
            r_state <= ST_COUNT;
          end
        ST_COUNT:
          if (!enable) r_state <= ST_IDLE;
          else if (w_step_edge) begin
            r_steps <= w_steps_inc;
            if (w_final) begin
              spike_count0 <= w_n0;
              spike_count1 <= w_n1;
              winner       <= w_win_code;
              result_valid <= 1'b1;
              r_state      <= ST_REPORT;
            end
          end
        ST_REPORT:
          if (result_ack) begin
            result_valid <= 1'b0;
            r_win        <= w_win_len;
            r_steps      <= '0;
            r_state      <= enable ? ST_COUNT : ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed and randomized windows checked against a spike-sum reference model
module tb_spike_rate_decoder;
  logic       system_clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       time_step = 1'b0;
  logic [1:0] output_spikes = 2'b00;
  logic [7:0] window_len = 8'd0;
  logic       result_ack = 1'b0;
  logic [7:0] spike_count0;
  logic [7:0] spike_count1;
  logic [1:0] winner;
  logic       result_valid;
  logic       busy;
  int         vectors = 0;
  int         miscompares = 0;
  int         e0 = 0;
  int         e1 = 0;
  logic [1:0] ew = 2'b00;
  logic [1:0] pat[$];

  spike_rate_decoder dut (
    .system_clock(system_clock), .reset(reset), .enable(enable), .time_step(time_step),
    .output_spikes(output_spikes), .window_len(window_len), .result_ack(result_ack),
    .spike_count0(spike_count0), .spike_count1(spike_count1), .winner(winner),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 system_clock = ~system_clock;

  function automatic logic [1:0] win_of(input int a, input int b);
    return (a > b) ? 2'b01 : (b > a) ? 2'b10 : (a != 0) ? 2'b11 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic v);
    chk({tag, ".valid"}, 32'(result_valid), 32'(v));
    chk({tag, ".count0"}, 32'(spike_count0), e0);
    chk({tag, ".count1"}, 32'(spike_count1), e1);
    chk({tag, ".winner"}, 32'(winner), 32'(ew));
  endtask

  // returns one negedge after the clock cycle holding the rising edge of time_step
  task automatic step(input logic [1:0] s);
    repeat ($urandom_range(0, 2)) @(negedge system_clock);
    @(negedge system_clock);
    time_step = 1'b1;
    output_spikes = s;
    @(negedge system_clock);
    time_step = 1'b0;
    output_spikes = 2'($urandom);
  endtask

  task automatic start(input int len);
    window_len = 8'(len);
    enable = 1'b1;
    @(negedge system_clock);
    chk("start.busy", 32'(busy), 1);
  endtask

  task automatic ack(input logic en, input int len);
    window_len = 8'(len);
    enable = en;
    result_ack = 1'b1;
    @(negedge system_clock);
    result_ack = 1'b0;
    chk("ack.valid", 32'(result_valid), 0);
    chk("ack.busy", 32'(busy), 32'(en));
  endtask

  task automatic play(input string tag);
    int s0 = 0;
    int s1 = 0;
    foreach (pat[i]) begin
      step(pat[i]);
      s0 += int'(pat[i][0]);
      s1 += int'(pat[i][1]);
      if (i < pat.size() - 1) chk({tag, ".early_valid"}, 32'(result_valid), 0);
    end
    e0 = (s0 > 255) ? 255 : s0;
    e1 = (s1 > 255) ? 255 : s1;
    ew = win_of(e0, e1);
    chk_res(tag, 1'b1);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  initial begin
    int len;
    repeat (3) @(negedge system_clock);
    chk_res("reset", 1'b0);
    chk("reset.busy", 32'(busy), 0);
    reset = 1'b1;
    @(negedge system_clock);
    chk("idle.busy", 32'(busy), 0);
    start(4);
    pat = '{2'b01, 2'b11, 2'b01, 2'b00};
    play("w4");
    ack(1'b0, 0);
    start(0);
    pat.delete();
    repeat (256) pat.push_back(2'b11);
    play("w256");
    ack(1'b0, 0);
    start(3);
    pat = '{2'b00, 2'b00, 2'b00};
    play("w3");
    repeat (20) step(2'b11);
    chk_res("hold", 1'b1);
    chk("hold.busy", 32'(busy), 0);
    ack(1'b1, 2);
    pat = '{2'b10, 2'b10};
    play("w2");
    ack(1'b1, 5);
    step(2'b11);
    step(2'b11);
    enable = 1'b0;
    @(negedge system_clock);
    chk("abort.busy", 32'(busy), 0);
    chk_res("abort", 1'b0);
    step(2'b11);
    chk_res("abort_idle", 1'b0);
    repeat (6) begin
      len = $urandom_range(1, 12);
      start(len);
      pat.delete();
      repeat (len) pat.push_back(2'($urandom));
      play("rand");
      ack(1'b0, 0);
    end
    start(3);
    step(2'b01);
    step(2'b10);
    @(negedge system_clock);
    time_step = 1'b1;
    output_spikes = 2'b11;
    enable = 1'b0;
    @(negedge system_clock);
    time_step = 1'b0;
    chk_res("abort_final", 1'b0);
    chk("abort_final.busy", 32'(busy), 0);
    start(2);
    @(negedge system_clock);
    time_step = 1'b1;
    output_spikes = 2'b01;
    repeat (10) @(negedge system_clock);
    time_step = 1'b0;
    @(negedge system_clock);
    chk("held.valid", 32'(result_valid), 0);
    chk("held.busy", 32'(busy), 1);
    step(2'b01);
    e0 = 2;
    e1 = 0;
    ew = 2'b01;
    chk_res("held", 1'b1);
    ack(1'b0, 0);
    start(5);
    step(2'b11);
    step(2'b11);
    #2 reset = 1'b0;
    #1;
    e0 = 0;
    e1 = 0;
    ew = 2'b00;
    chk_res("async_reset", 1'b0);
    chk("async_reset.busy", 32'(busy), 0);
    enable = 1'b0;
    @(negedge system_clock);
    reset = 1'b1;
    @(negedge system_clock);
    chk("post_reset.busy", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
